// File: rtl/wb_writer_pkg.sv
// rtl/wb_writer_pkg.sv - shared writeback constants and result type
package wb_writer_pkg;

  localparam int XLEN      = 64;
  localparam int NREG      = 32;
  localparam int REG_IDX_W = 5;

  typedef struct packed {
    logic [REG_IDX_W-1:0] rd;
    logic [XLEN-1:0]      data;
  } wb_result_t;

  localparam int WB_RESULT_W = $bits(wb_result_t);

endpackage

// File: rtl/wb_writer_fifo.sv
// rtl/wb_writer_fifo.sv - synchronous FIFO with occupancy count, staging LSU results
module wb_fifo #(
  parameter int W     = 69,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [W-1:0]  push_data_i,
  input  logic          pop_i,
  output logic [W-1:0]  head_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/wb_writer.sv
// rtl/wb_writer.sv - register file write-port owner: ALU/LSU arbitration, output register, pending scoreboard
module wb_writer
  import wb_writer_pkg::*;
#(
  parameter int LSU_DEPTH = 4,
  localparam int CNT_W    = $clog2(LSU_DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 issue_valid,
  input  logic [REG_IDX_W-1:0] issue_rd,
  input  logic                 alu_valid,
  output logic                 alu_ready,
  input  logic [REG_IDX_W-1:0] alu_rd,
  input  logic [XLEN-1:0]      alu_data,
  input  logic                 lsu_valid,
  output logic                 lsu_ready,
  input  logic [REG_IDX_W-1:0] lsu_rd,
  input  logic [XLEN-1:0]      lsu_data,
  output logic                 rf_wen,
  output logic [REG_IDX_W-1:0] rf_waddr,
  output logic [XLEN-1:0]      rf_wdata,
  output logic [NREG-1:0]      sb_busy,
  output logic [CNT_W-1:0]     lsu_count
);

  wb_result_t           alu_res, lsu_res, fifo_head, sel_res;
  logic                 fifo_full, fifo_empty, fifo_pop, alu_sel, any_sel;
  logic                 rf_wen_d, rf_wen_q;
  logic [REG_IDX_W-1:0] rf_waddr_d, rf_waddr_q;
  logic [XLEN-1:0]      rf_wdata_d, rf_wdata_q;
  logic [NREG-1:0]      sb_busy_d, sb_busy_q;

  assign alu_res = '{rd: alu_rd, data: alu_data};
  assign lsu_res = '{rd: lsu_rd, data: lsu_data};

  wb_fifo #(.W(WB_RESULT_W), .DEPTH(LSU_DEPTH)) u_lsu_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (lsu_valid),
    .push_data_i(lsu_res),
    .pop_i      (fifo_pop),
    .head_o     (fifo_head),
    .count_o    (lsu_count),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  // A full FIFO takes priority so the LSU can never be starved by a streaming ALU.
  assign alu_ready = !fifo_full;
  assign lsu_ready = !fifo_full;
  assign alu_sel   = alu_valid && !fifo_full;
  assign fifo_pop  = !fifo_empty && !alu_sel;
  assign any_sel   = alu_sel || fifo_pop;

  always_comb begin
    sel_res    = alu_sel ? alu_res : fifo_head;
    rf_wen_d   = any_sel && (sel_res.rd != '0);
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (any_sel) begin
      rf_waddr_d = sel_res.rd;
      rf_wdata_d = sel_res.data;
    end
  end

  // Set after clear so a re-issue on the committing edge keeps the bit.
  always_comb begin
    sb_busy_d = sb_busy_q;
    if (rf_wen_q)    sb_busy_d[rf_waddr_q] = 1'b0;
    if (issue_valid) sb_busy_d[issue_rd]   = 1'b1;
    sb_busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_wen_q   <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      sb_busy_q  <= '0;
    end else begin
      rf_wen_q   <= rf_wen_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      sb_busy_q  <= sb_busy_d;
    end
  end

  assign rf_wen   = rf_wen_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign sb_busy  = sb_busy_q;

  a_no_waw: assert property (@(posedge clk) disable iff (rst)
    (issue_valid && issue_rd != '0) |->
      (!sb_busy_q[issue_rd] || (rf_wen_q && rf_waddr_q == issue_rd)))
    else $error("issue to register with write still pending");

  a_alu_pending: assert property (@(posedge clk) disable iff (rst)
    (alu_valid && alu_ready && alu_rd != '0) |-> sb_busy_q[alu_rd])
    else $error("ALU result for register not pending");

  a_lsu_pending: assert property (@(posedge clk) disable iff (rst)
    (lsu_valid && lsu_ready && lsu_rd != '0) |-> sb_busy_q[lsu_rd])
    else $error("LSU result for register not pending");

endmodule

// File: tb/tb_wb_writer.sv
// tb/tb_wb_writer.sv - randomized self-checking bench for wb_writer against a queue-based model
module tb_wb_writer;
  import wb_writer_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        issue_valid = 1'b0;
  logic [4:0]  issue_rd = '0;
  logic        alu_valid = 1'b0;
  logic        alu_ready;
  logic [4:0]  alu_rd = '0;
  logic [63:0] alu_data = '0;
  logic        lsu_valid = 1'b0;
  logic        lsu_ready;
  logic [4:0]  lsu_rd = '0;
  logic [63:0] lsu_data = '0;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [63:0] rf_wdata;
  logic [31:0] sb_busy;
  logic [2:0]  lsu_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  wb_writer #(.LSU_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .issue_valid(issue_valid),
    .issue_rd   (issue_rd),
    .alu_valid  (alu_valid),
    .alu_ready  (alu_ready),
    .alu_rd     (alu_rd),
    .alu_data   (alu_data),
    .lsu_valid  (lsu_valid),
    .lsu_ready  (lsu_ready),
    .lsu_rd     (lsu_rd),
    .lsu_data   (lsu_data),
    .rf_wen     (rf_wen),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .sb_busy    (sb_busy),
    .lsu_count  (lsu_count)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural model: a plain queue for the LSU FIFO and a bit vector of pending writes.
  wb_result_t  m_q[$];
  logic        m_wen   = 1'b0;
  logic [4:0]  m_waddr = '0;
  logic [63:0] m_wdata = '0;
  logic [31:0] m_busy  = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q.delete();
      m_wen   = 1'b0;
      m_waddr = '0;
      m_wdata = '0;
      m_busy  = '0;
    end else begin : step
      wb_result_t sel;
      bit have;
      bit full;
      full = (m_q.size() == DEPTH);
      have = 1'b1;
      sel  = '0;
      if (full || (!alu_valid && m_q.size() > 0)) sel = m_q.pop_front();
      else if (alu_valid) sel = '{rd: alu_rd, data: alu_data};
      else have = 1'b0;
      if (lsu_valid && !full) m_q.push_back('{rd: lsu_rd, data: lsu_data});
      if (m_wen) m_busy[m_waddr] = 1'b0;
      if (issue_valid && issue_rd != 0) m_busy[issue_rd] = 1'b1;
      m_wen = have && (sel.rd != 0);
      if (have) begin
        m_waddr = sel.rd;
        m_wdata = sel.data;
      end
    end
  end

  always @(negedge clk) begin
    chk("alu_ready", alu_ready, m_q.size() != DEPTH);
    chk("lsu_ready", lsu_ready, m_q.size() != DEPTH);
    chk("lsu_count", lsu_count, m_q.size());
    chk("rf_wen",    rf_wen,    m_wen);
    chk("rf_waddr",  rf_waddr,  m_waddr);
    chk("rf_wdata",  rf_wdata,  m_wdata);
    chk("sb_busy",   sb_busy,   m_busy);
  end

  logic [31:0] outst = '0;

  function automatic bit pick(output logic [4:0] rd);
    int s;
    s = $urandom_range(31);
    for (int k = 0; k < 32; k++) begin
      if (outst[(s + k) % 32]) begin
        rd = 5'((s + k) % 32);
        return 1'b1;
      end
    end
    rd = '0;
    return ($urandom_range(7) == 0);
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid = 1'b0;
    alu_valid   = 1'b0;
    lsu_valid   = 1'b0;
  endtask

  initial begin
    logic       alu_fire, lsu_fire;
    logic [4:0] r;

    idle();
    tick();
    tick();
    rst = 1'b0;
    chk("reset_wen",   rf_wen, 0);
    chk("reset_busy",  sb_busy, 0);
    chk("reset_count", lsu_count, 0);
    chk("reset_alu_ready", alu_ready, 1);

    // Reset mid-stream with three LSU results queued.
    issue_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      issue_rd = 5'(i);
      tick();
    end
    issue_valid = 1'b0;
    alu_valid = 1'b1; alu_rd = '0; alu_data = 64'hAA; lsu_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      lsu_rd = 5'(i); lsu_data = 64'(256 + i);
      tick();
    end
    idle();
    chk("t1_count_before_rst", lsu_count, 3);
    chk("t1_busy_before_rst", sb_busy, 32'h0000_000E);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t1_count", lsu_count, 0);
    chk("t1_busy", sb_busy, 0);
    chk("t1_wen", rf_wen, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t1_no_flushed_write", rf_wen, 0);
    end

    // Simple ALU writeback.
    issue_valid = 1'b1; issue_rd = 5'd5;
    tick();
    issue_valid = 1'b0;
    chk("t2_busy_set", sb_busy[5], 1);
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 64'hDEAD_BEEF;
    chk("t2_alu_ready", alu_ready, 1);
    tick();
    alu_valid = 1'b0;
    chk("t2_wen", rf_wen, 1);
    chk("t2_waddr", rf_waddr, 5);
    chk("t2_wdata", rf_wdata, 64'hDEAD_BEEF);
    chk("t2_busy_during_commit", sb_busy[5], 1);
    tick();
    chk("t2_busy_clear", sb_busy[5], 0);
    chk("t2_wen_low", rf_wen, 0);

    // ALU beats a non-full FIFO.
    issue_valid = 1'b1; issue_rd = 5'd7; tick();
    issue_rd = 5'd9; tick();
    issue_valid = 1'b0;
    lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 64'h11;
    tick();
    lsu_valid = 1'b0;
    chk("t3_count1", lsu_count, 1);
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 64'h22;
    chk("t3_alu_ready_a", alu_ready, 1);
    tick();
    chk("t3_alu_ready_b", alu_ready, 1);
    chk("t3_waddr_a", rf_waddr, 9);
    tick();
    alu_valid = 1'b0;
    chk("t3_waddr_b", rf_waddr, 9);
    chk("t3_count_hold", lsu_count, 1);
    tick();
    chk("t3_waddr_c", rf_waddr, 7);
    chk("t3_wdata_c", rf_wdata, 64'h11);
    chk("t3_count_drained", lsu_count, 0);
    tick();

    // FIFO full: head wins, ALU stalls.
    issue_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      issue_rd = 5'(i);
      tick();
    end
    issue_rd = 5'd10; tick();
    issue_valid = 1'b0;
    alu_valid = 1'b1; alu_rd = '0; alu_data = '0; lsu_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      lsu_rd = 5'(i); lsu_data = 64'(512 + i);
      tick();
    end
    lsu_valid = 1'b0;
    chk("t4_count_full", lsu_count, 4);
    chk("t4_lsu_ready", lsu_ready, 0);
    chk("t4_alu_ready", alu_ready, 0);
    alu_rd = 5'd10; alu_data = 64'hA0;
    tick();
    chk("t4_first_waddr", rf_waddr, 1);
    chk("t4_first_wdata", rf_wdata, 64'h201);
    chk("t4_alu_ready_after", alu_ready, 1);
    tick();
    alu_valid = 1'b0;
    chk("t4_alu_waddr", rf_waddr, 10);
    chk("t4_alu_wdata", rf_wdata, 64'hA0);
    tick(); chk("t4_waddr2", rf_waddr, 2);
    tick(); chk("t4_waddr3", rf_waddr, 3);
    tick(); chk("t4_waddr4", rf_waddr, 4);
    tick(); chk("t4_count_empty", lsu_count, 0);

    // x0 results and issues.
    chk("t5_busy_before", sb_busy, 0);
    alu_valid = 1'b1; alu_rd = '0; alu_data = 64'hFF;
    issue_valid = 1'b1; issue_rd = '0;
    chk("t5_alu_ready", alu_ready, 1);
    tick();
    idle();
    chk("t5_wen", rf_wen, 0);
    chk("t5_busy", sb_busy, 0);
    tick();

    // Re-issue on the committing edge: set beats clear.
    issue_valid = 1'b1; issue_rd = 5'd12; tick();
    issue_valid = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd12; alu_data = 64'h12;
    tick();
    alu_valid = 1'b0;
    chk("t6_wen", rf_wen, 1);
    chk("t6_waddr", rf_waddr, 12);
    issue_valid = 1'b1; issue_rd = 5'd12;
    tick();
    issue_valid = 1'b0;
    chk("t6_busy_kept", sb_busy[12], 1);
    alu_valid = 1'b1; alu_rd = 5'd12; alu_data = 64'h34;
    tick();
    alu_valid = 1'b0;
    tick();
    chk("t6_busy_clear", sb_busy[12], 0);

    // Randomized traffic.
    outst = '0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      alu_fire = alu_valid && alu_ready;
      lsu_fire = lsu_valid && lsu_ready;
      #1;
      issue_valid = 1'b0;
      if (!alu_valid || alu_fire) begin
        alu_valid = 1'b0;
        if ($urandom_range(99) < 65 && pick(r)) begin
          alu_valid = 1'b1; alu_rd = r; alu_data = {$urandom, $urandom};
          outst[r] = 1'b0;
        end
      end
      if (!lsu_valid || lsu_fire) begin
        lsu_valid = 1'b0;
        if ($urandom_range(99) < 50 && pick(r)) begin
          lsu_valid = 1'b1; lsu_rd = r; lsu_data = {$urandom, $urandom};
          outst[r] = 1'b0;
        end
      end
      if ($urandom_range(99) < 70) begin
        r = 5'($urandom_range(31));
        if (r == 0 || (!m_busy[r] && !outst[r])) begin
          issue_valid = 1'b1; issue_rd = r;
          if (r != 0) outst[r] = 1'b1;
        end
      end
    end

    // Drain held results, then pin the final state.
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      alu_fire = alu_valid && alu_ready;
      lsu_fire = lsu_valid && lsu_ready;
      #1;
      issue_valid = 1'b0;
      if (alu_fire) alu_valid = 1'b0;
      if (lsu_fire) lsu_valid = 1'b0;
    end
    chk("final_alu_idle", alu_valid, 0);
    chk("final_lsu_idle", lsu_valid, 0);
    chk("final_count", lsu_count, 0);
    chk("final_wen", rf_wen, 0);
    chk("final_busy", sb_busy, outst);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_writer.md
Name: wb_writer

Overview:
- Writeback-side producer for the 32x64 integer register file: owns the file's single write port (wen/waddr/wdata) and feeds it from two result sources.
  - ALU: single-cycle results.
  - LSU: variable-latency load results, staged through a small FIFO.
- Keeps a per-register pending scoreboard so decode/issue can stall reads of registers whose writes are still in flight.
- Sits between the execute units and the register file.

Parameters:
- XLEN, 64, data width.
- NREG, 32, architectural register count; index width is 5.
- LSU_DEPTH, 4, LSU result FIFO entries (power of two, >=2).

Ports:
- clk  input  1  clock.
- rst  input  1  reset; asynchronous, active-high.
- issue_valid  input  1  an instruction writing issue_rd issues this cycle.
- issue_rd  input  5  destination of the issuing instruction.
- alu_valid  input  1  ALU result presented.
- alu_ready  output  1  ALU result accepted this cycle.
- alu_rd  input  5  ALU destination.
- alu_data  input  XLEN  ALU result.
- lsu_valid  input  1  LSU result presented.
- lsu_ready  output  1  LSU FIFO can accept.
- lsu_rd  input  5  LSU destination.
- lsu_data  input  XLEN  LSU result.
- rf_wen  output  1  register file write enable.
- rf_waddr  output  5  register file write index.
- rf_wdata  output  XLEN  register file write data.
- sb_busy  output  NREG  bit r = 1: write to xr pending.
- lsu_count  output  3  FIFO occupancy, 0..LSU_DEPTH.

Behaviour:
- Reset (async assert, sync release):
  - rf_wen=0, rf_waddr=0, rf_wdata=0.
  - sb_busy=0, FIFO empty, lsu_count=0.
  - alu_ready and lsu_ready are combinational; both read 1 while in reset-released empty state.
  - Reset mid-operation discards all FIFO contents and pending bits; no write is issued in the cycle rst is high.
- LSU FIFO:
  - lsu_ready = (lsu_count != LSU_DEPTH); no same-cycle pop-through when full.
  - Push on lsu_valid && lsu_ready; pop when the head is selected for writeback.
  - Simultaneous push and pop keeps the count unchanged.
  - Pointers wrap modulo LSU_DEPTH.
- Write-port arbitration, one write per cycle:
  - FIFO full: FIFO head wins; alu_ready=0.
  - Otherwise, alu_valid: ALU wins; alu_ready=1; FIFO head waits.
  - Otherwise, FIFO non-empty: FIFO head wins.
  - alu_ready=1 whenever FIFO is not full, even if alu_valid=0.
- Output register:
  - The selected result is registered: rf_wen/rf_waddr/rf_wdata are valid the cycle after acceptance (ALU) or pop (FIFO). Latency is 1 cycle.
  - rf_wen=1 only when the selected rd != 0. A result with rd=0 is consumed (handshake completes, FIFO pops) but produces rf_wen=0.
  - When nothing is selected, rf_wen=0 and rf_waddr/rf_wdata hold their last value.
- Scoreboard:
  - On issue_valid with issue_rd!=0: set sb_busy[issue_rd] at the next edge.
  - On rf_wen=1: clear sb_busy[rf_waddr] at that edge, i.e. busy drops in the same cycle the register file commits the data.
  - Set and clear to the same register on the same edge: set wins.
  - sb_busy[0] is constantly 0.
- Illegal conditions (simulation assertion, no RTL recovery):
  - issue_valid with sb_busy[issue_rd]=1; upstream must stall WAW.
  - A result arriving for a register whose busy bit is 0.
- No internal combinational path from alu_valid/lsu_valid to rf_*; alu_ready depends only on lsu_count.

Decomposition:
- Shared package, e.g. core_pkg:
  - XLEN and NREG constants.
  - REG_IDX_W=5.
  - A wb_result struct typedef {rd, data}, used by the ALU, the LSU and this block.
- One natural sub-module: wb_fifo (parameterised synchronous FIFO, data width 5+XLEN, async active-high reset, count output).
- Arbitration, output register and scoreboard stay in wb_writer.

Test Plan:
- Reset mid-stream: push 3 LSU results, assert rst for 1 cycle -> lsu_count=0, sb_busy=0, rf_wen=0 next cycle, no write of the flushed data.
- Simple ALU writeback: issue rd=5; then alu_valid rd=5 data=0xDEAD_BEEF -> sb_busy[5]=1 after issue; rf_wen=1, waddr=5, wdata=0xDEADBEEF one cycle after acceptance; sb_busy[5]=0 on that edge.
- Contention, FIFO not full: FIFO holds rd=7 data=0x11; alu_valid rd=9 data=0x22 each cycle for 2 cycles -> writes 9, 9, then 7 when ALU idles; alu_ready stays 1.
- FIFO full: fill 4 LSU entries (rd=1..4) while ALU is streaming -> lsu_ready=0, alu_ready=0; writes 1 drains first, then ALU; FIFO wraps correctly over 10+ pushes with in-order data.
- x0 handling: ALU result rd=0 data=0xFF -> alu_ready=1, rf_wen=0, sb_busy unchanged; issue_rd=0 never sets a bit.
- Set/clear same edge: rf_wen writes rd=12 while issue_valid rd=12 on the same cycle -> sb_busy[12]=1 afterwards.
